// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: shared types and constants for the counter-chain sequencer.
//   state_t   FSM states IDLE, LOAD, RUN, DONE
//   NREQ      number of requesters
//   REQ_VIDEO requester index of the video scan
//   REQ_CPU   requester index of the CPU/DMA
package cnt_seq_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   localparam int NREQ = 2;
   localparam int REQ_VIDEO = 0;
   localparam int REQ_CPU = 1;
endpackage

// File: rtl/cnt_seq_arbiter.sv
// cnt_seq_arbiter: picks one requester for the counter chain.
//   req    in  NREQ  request levels
//   last   in  1     requester granted most recently
//   enable in  1     grant window (tick while idle)
//   gnt    out NREQ  one-hot grant, zero when not enabled
// Build macro CNT_SEQ_RR_ARB_EN: round-robin ties (last loses); otherwise requester 0 wins ties.
module cnt_seq_arbiter
   import cnt_seq_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic            last,
   input  logic            enable,
   output logic [NREQ-1:0] gnt
);
   logic pick1;
`ifdef CNT_SEQ_RR_ARB_EN
   assign pick1 = req[REQ_CPU] & (~req[REQ_VIDEO] | ~last);
`else
   logic unused_last;
   assign unused_last = last;
   assign pick1 = req[REQ_CPU] & ~req[REQ_VIDEO];
`endif
   assign gnt = enable ? {pick1, ~pick1 & req[REQ_VIDEO]} : '0;
endmodule

// File: rtl/cnt_chain_sequencer.sv
// cnt_chain_sequencer: grants a 74163-style counter chain, loads it and runs it for a requested count.
//   Clk, Rst(async, high), Cen  clock, reset, shared enable strobe (rising edge = tick)
//   req, start0/1, len0/1       requests plus load values and run lengths sampled at grant
//   gnt, done, busy             one-hot grant, one-Clk completion pulse, not idle
//   cnt_load_n/ent/enp/d, rco   counter chain control, load data and ripple carry
// Build macro CNT_SEQ_RR_ARB_EN selects round-robin arbitration (see cnt_seq_arbiter).
module cnt_chain_sequencer
   import cnt_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Cen,
   input  logic [NREQ-1:0]   req,
   input  logic [WIDTH-1:0]  start0,
   input  logic [WIDTH-1:0]  start1,
   input  logic [LEN_W-1:0]  len0,
   input  logic [LEN_W-1:0]  len1,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic              cnt_load_n,
   output logic              cnt_ent,
   output logic              cnt_enp,
   output logic [WIDTH-1:0]  cnt_d,
   input  logic              cnt_rco
);
   state_t state, state_n;
   logic cen_q, tick, last, abort;
   logic [LEN_W-1:0] rem;
   logic [NREQ-1:0] arb_gnt;
   // the chain wraps silently; its carry plays no part in sequencing
   logic unused_rco;
   assign unused_rco = cnt_rco;
   // same edge rule as the chain, so both act on the same Clk
   assign tick = Cen & ~cen_q;
   assign abort = (gnt & req) == '0;
   cnt_seq_arbiter u_arb (
      .req(req),
      .last(last),
      .enable(tick && state == IDLE),
      .gnt(arb_gnt)
   );
   always_comb begin
      state_n = state;
      cnt_load_n = 1'b1;
      cnt_ent = 1'b0;
      cnt_enp = 1'b0;
      busy = state != IDLE;
      case (state)
         IDLE: state_n = arb_gnt != '0 ? LOAD : IDLE;
         LOAD: begin
            cnt_load_n = 1'b0;
            if (tick) state_n = abort ? IDLE : rem == '0 ? DONE : RUN;
         end
         RUN: begin
            cnt_ent = 1'b1;
            cnt_enp = 1'b1;
            if (tick) state_n = abort ? IDLE : rem == LEN_W'(1) ? DONE : RUN;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= IDLE;
         cen_q <= 1'b1;
         gnt <= '0;
         done <= '0;
         cnt_d <= '0;
         rem <= '0;
         last <= 1'b1;
      end else begin
         state <= state_n;
         cen_q <= Cen;
         done <= '0;
         if (state == IDLE && arb_gnt != '0) begin
            gnt <= arb_gnt;
            cnt_d <= arb_gnt[REQ_CPU] ? start1 : start0;
            rem <= arb_gnt[REQ_CPU] ? len1 : len0;
            last <= arb_gnt[REQ_CPU];
         end
         if (state == RUN && tick && rem != '0) rem <= rem - LEN_W'(1);
         // leaving LOAD/RUN for DONE or IDLE drops the grant; only DONE reports completion
         if ((state == LOAD || state == RUN) && (state_n == DONE || state_n == IDLE)) begin
            gnt <= '0;
            done <= state_n == DONE ? gnt : '0;
         end
      end
   end
endmodule

// File: tb/tb_cnt_chain_sequencer.sv
// tb_cnt_chain_sequencer: directed vector table plus abort and reset sequences against a counter chain model.
module tb_cnt_chain_sequencer;
   logic Clk = 1'b0, Rst = 1'b1, Cen = 1'b0;
   logic [1:0] req = 2'b00;
   logic [7:0] start0 = '0, start1 = '0, len0 = '0, len1 = '0;
   logic [1:0] gnt, done;
   logic busy, cnt_load_n, cnt_ent, cnt_enp, cnt_rco;
   logic [7:0] cnt_d;
   int n_pass = 0, n_tot = 0;
   always #5 Clk = ~Clk;
   cnt_chain_sequencer dut (
      .Clk(Clk), .Rst(Rst), .Cen(Cen), .req(req),
      .start0(start0), .start1(start1), .len0(len0), .len1(len1),
      .gnt(gnt), .done(done), .busy(busy),
      .cnt_load_n(cnt_load_n), .cnt_ent(cnt_ent), .cnt_enp(cnt_enp),
      .cnt_d(cnt_d), .cnt_rco(cnt_rco)
   );
   logic [7:0] chain = 8'h00;
   logic m_cenq = 1'b1;
   int rco_n = 0, d0_n = 0, d1_n = 0, ent_n = 0;
   always @(posedge Clk) begin
      m_cenq <= Cen;
      if (Cen && !m_cenq) begin
         if (!cnt_load_n) chain <= cnt_d;
         else if (cnt_ent && cnt_enp) begin
            chain <= chain + 8'h01;
            if (chain == 8'hFF) rco_n <= rco_n + 1;
         end
      end
   end
   assign cnt_rco = (chain == 8'hFF) & cnt_ent & cnt_enp;
   always @(negedge Clk) begin
      if (done[0]) d0_n <= d0_n + 1;
      if (done[1]) d1_n <= d1_n + 1;
      if (cnt_ent) ent_n <= ent_n + 1;
   end
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
   endtask
   task automatic do_tick;
      @(negedge Clk) Cen = 1'b1;
      @(negedge Clk) Cen = 1'b0;
      repeat (2) @(negedge Clk);
   endtask
   typedef struct {
      logic [1:0] req;
      logic [7:0] s0, s1, l0, l1;
      logic [1:0] gnt;
      logic [7:0] chain;
      int d0, d1, ticks, rco;
      logic ent;
   } vec_t;
   vec_t v[5];
   initial begin
      int b0, b1, br, be, t;
      logic [1:0] g;
      v[0] = '{2'b01, 8'h10, 8'h00, 8'd3, 8'd0, 2'b01, 8'h13, 1, 0, 5, 0, 1'b1};
      v[1] = '{2'b10, 8'h00, 8'hFE, 8'd0, 8'd0, 2'b10, 8'hFE, 0, 1, 2, 0, 1'b0};
      v[2] = '{2'b11, 8'h30, 8'h50, 8'd1, 8'd2, 2'b01, 8'h31, 1, 0, 3, 0, 1'b1};
`ifdef CNT_SEQ_RR_ARB_EN
      v[3] = '{2'b11, 8'h40, 8'h50, 8'd2, 8'd2, 2'b10, 8'h52, 0, 1, 4, 0, 1'b1};
`else
      v[3] = '{2'b11, 8'h40, 8'h50, 8'd2, 8'd2, 2'b01, 8'h42, 1, 0, 4, 0, 1'b1};
`endif
      v[4] = '{2'b01, 8'hFE, 8'h00, 8'd4, 8'd0, 2'b01, 8'h02, 1, 0, 6, 1, 1'b1};
      repeat (2) @(negedge Clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_load_n", 32'(cnt_load_n), 1);
      chk("rst_ent", 32'(cnt_ent), 0);
      chk("rst_enp", 32'(cnt_enp), 0);
      chk("rst_d", 32'(cnt_d), 0);
      Rst = 1'b0;
      @(negedge Clk);
      for (int i = 0; i < 5; i++) begin
         req = v[i].req; start0 = v[i].s0; start1 = v[i].s1; len0 = v[i].l0; len1 = v[i].l1;
         b0 = d0_n; b1 = d1_n; br = rco_n; be = ent_n;
         do_tick;
         g = gnt;
         t = 1;
         while (busy && t < 40) begin
            do_tick;
            t++;
         end
         req = 2'b00;
         chk($sformatf("v%0d_gnt", i), 32'(g), 32'(v[i].gnt));
         chk($sformatf("v%0d_chain", i), 32'(chain), 32'(v[i].chain));
         chk($sformatf("v%0d_done0", i), 32'(d0_n - b0), 32'(v[i].d0));
         chk($sformatf("v%0d_done1", i), 32'(d1_n - b1), 32'(v[i].d1));
         chk($sformatf("v%0d_ticks", i), 32'(t), 32'(v[i].ticks));
         chk($sformatf("v%0d_rco", i), 32'(rco_n - br), 32'(v[i].rco));
         chk($sformatf("v%0d_ent", i), 32'(ent_n != be), 32'(v[i].ent));
         chk($sformatf("v%0d_gnt_end", i), 32'(gnt), 0);
      end
      // abort in RUN with two counts left
      req = 2'b01; start0 = 8'h20; len0 = 8'd5;
      b0 = d0_n;
      repeat (5) do_tick;
      chk("ab_chain_pre", 32'(chain), 32'h23);
      chk("ab_ent_pre", 32'(cnt_ent), 1);
      req = 2'b00;
      do_tick;
      chk("ab_ent", 32'(cnt_ent), 0);
      chk("ab_enp", 32'(cnt_enp), 0);
      chk("ab_gnt", 32'(gnt), 0);
      chk("ab_busy", 32'(busy), 0);
      chk("ab_chain", 32'(chain), 32'h24);
      repeat (2) do_tick;
      chk("ab_frozen", 32'(chain), 32'h24);
      chk("ab_no_done", 32'(d0_n - b0), 0);
      // reset mid RUN with Cen held high across release
      req = 2'b01; start0 = 8'h60; len0 = 8'd5;
      repeat (3) do_tick;
      chk("rs_chain_pre", 32'(chain), 32'h61);
      #2 Rst = 1'b1;
      @(negedge Clk) Cen = 1'b1;
      repeat (2) @(negedge Clk);
      chk("rs_gnt", 32'(gnt), 0);
      chk("rs_busy", 32'(busy), 0);
      chk("rs_load_n", 32'(cnt_load_n), 1);
      chk("rs_ent", 32'(cnt_ent), 0);
      chk("rs_d", 32'(cnt_d), 0);
      Rst = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rs_no_tick_busy", 32'(busy), 0);
      chk("rs_chain", 32'(chain), 32'h61);
      Cen = 1'b0;
      repeat (2) @(negedge Clk);
      do_tick;
      chk("rs_regrant", 32'(gnt), 32'h1);
      chk("rs_busy_after", 32'(busy), 1);
      req = 2'b00;
      do_tick;
      chk("rs_abort_idle", 32'(busy), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
